// File: rtl/i2c_target_regs.sv
// I2C target that bridges bus transactions onto a simple register port.
// SCL/SDA are oversampled on CLK; SDA is driven open-drain, SCL is never driven.
module i2c_target_regs #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned REG_AW   = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    output logic [REG_AW-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_PTR    = 3'd2,
        ST_WRITE  = 3'd3,
        ST_READ   = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    localparam logic [REG_AW-1:0] ADDR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

    logic scl_meta_r, scl_sync_r, scl_prev_r;
    logic sda_meta_r, sda_sync_r, sda_prev_r;

    state_t            state_r, state_nxt_s;
    logic [3:0]        bit_cnt_r, bit_cnt_nxt_s;
    logic [7:0]        rx_r, rx_nxt_s;
    logic [7:0]        tx_r, tx_nxt_s;
    logic              ack_r, ack_nxt_s;
    logic              sda_oe_r, sda_oe_nxt_s;
    logic [REG_AW-1:0] reg_addr_r, addr_nxt_s;
    logic [7:0]        reg_wdata_r, wdata_nxt_s;
    logic              reg_we_r, we_nxt_s;
    logic              reg_re_r, re_nxt_s;
    logic              busy_r, busy_nxt_s;

    logic       scl_rise_s, scl_fall_s, start_s, stop_s, active_s;
    logic [7:0] rx_byte_s;

    // Two-flop synchronisers plus previous-value stage for edge detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_prev_r <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_meta_r <= scl_in;
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda_in;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // START/STOP need SCL stable high across the SDA edge, so a joint change is neither.
    assign scl_rise_s = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r & scl_prev_r;
    assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
    assign rx_byte_s  = {rx_r[6:0], sda_sync_r};
    assign active_s   = (state_r == ST_ADDR) || (state_r == ST_PTR) ||
                        (state_r == ST_WRITE) || (state_r == ST_READ);

    // State and register-port registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 4'd0;
            rx_r        <= 8'h00;
            tx_r        <= 8'h00;
            ack_r       <= 1'b0;
            sda_oe_r    <= 1'b0;
            reg_addr_r  <= {REG_AW{1'b0}};
            reg_wdata_r <= 8'h00;
            reg_we_r    <= 1'b0;
            reg_re_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            rx_r        <= rx_nxt_s;
            tx_r        <= tx_nxt_s;
            ack_r       <= ack_nxt_s;
            sda_oe_r    <= sda_oe_nxt_s;
            reg_addr_r  <= addr_nxt_s;
            reg_wdata_r <= wdata_nxt_s;
            reg_we_r    <= we_nxt_s;
            reg_re_r    <= re_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    // Next-state logic: bit_cnt counts SCL rises in a 9-bit slot (8 data + ACK).
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        rx_nxt_s      = rx_r;
        tx_nxt_s      = tx_r;
        ack_nxt_s     = ack_r;
        sda_oe_nxt_s  = sda_oe_r;
        addr_nxt_s    = reg_addr_r;
        wdata_nxt_s   = reg_wdata_r;
        we_nxt_s      = 1'b0;
        re_nxt_s      = 1'b0;
        busy_nxt_s    = busy_r;

        if (reg_we_r) begin
            addr_nxt_s = reg_addr_r + ADDR_ONE;
        end else begin
            addr_nxt_s = reg_addr_r;
        end
        if (reg_re_r) begin
            tx_nxt_s = reg_rdata;
        end else begin
            tx_nxt_s = tx_r;
        end

        if (start_s) begin
            state_nxt_s   = ST_ADDR;
            bit_cnt_nxt_s = 4'd0;
            ack_nxt_s     = 1'b0;
            sda_oe_nxt_s  = 1'b0;
            busy_nxt_s    = 1'b1;
        end else if (stop_s) begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = 4'd0;
            ack_nxt_s     = 1'b0;
            sda_oe_nxt_s  = 1'b0;
            busy_nxt_s    = 1'b0;
        end else if (active_s && scl_rise_s) begin
            if (bit_cnt_r < 4'd8) begin
                rx_nxt_s      = rx_byte_s;
                bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                if (bit_cnt_r == 4'd7) begin
                    case (state_r)
                        ST_ADDR: begin
                            if (rx_byte_s[7:1] == DEV_ADDR) begin
                                ack_nxt_s = 1'b1;
                                if (rx_byte_s[0]) begin
                                    state_nxt_s = ST_READ;
                                    re_nxt_s    = 1'b1;
                                end else begin
                                    state_nxt_s = ST_PTR;
                                end
                            end else begin
                                ack_nxt_s   = 1'b0;
                                state_nxt_s = ST_IGNORE;
                            end
                        end
                        ST_PTR: begin
                            addr_nxt_s  = rx_byte_s[REG_AW-1:0];
                            ack_nxt_s   = 1'b1;
                            state_nxt_s = ST_WRITE;
                        end
                        ST_WRITE: begin
                            wdata_nxt_s = rx_byte_s;
                            we_nxt_s    = 1'b1;
                            ack_nxt_s   = 1'b1;
                        end
                        default: begin
                            ack_nxt_s = 1'b0;
                        end
                    endcase
                end else begin
                    ack_nxt_s = ack_r;
                end
            end else begin
                bit_cnt_nxt_s = 4'd9;
                // A read slot without our own ACK carries the master's ACK/NACK.
                if ((state_r == ST_READ) && !ack_r) begin
                    if (!sda_sync_r) begin
                        addr_nxt_s = reg_addr_r + ADDR_ONE;
                        re_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_IGNORE;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
        end else if (active_s && scl_fall_s) begin
            if (bit_cnt_r == 4'd8) begin
                sda_oe_nxt_s = ack_r;
            end else if (bit_cnt_r == 4'd9) begin
                bit_cnt_nxt_s = 4'd0;
                ack_nxt_s     = 1'b0;
                if (state_r == ST_READ) begin
                    sda_oe_nxt_s = ~tx_r[7];
                    tx_nxt_s     = {tx_r[6:0], 1'b0};
                end else begin
                    sda_oe_nxt_s = 1'b0;
                end
            end else if ((state_r == ST_READ) && (bit_cnt_r != 4'd0)) begin
                sda_oe_nxt_s = ~tx_r[7];
                tx_nxt_s     = {tx_r[6:0], 1'b0};
            end else begin
                sda_oe_nxt_s = sda_oe_r;
            end
        end else begin
            bit_cnt_nxt_s = bit_cnt_r;
        end
    end

    assign sda_oe    = sda_oe_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wdata = reg_wdata_r;
    assign reg_we    = reg_we_r;
    assign reg_re    = reg_re_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register-file model and
// a transaction-level expectation of pointer, write strobes and read bytes.
module tb_i2c_target_regs;

    localparam int         Q   = 4;
    localparam logic [6:0] DEV = 7'h50;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       scl_m, sda_m, sda_bus;
    logic       sda_oe, reg_we, reg_re, busy;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata;
    logic [7:0] rmem [0:15];
    logic [7:0] wdat [0:7];

    always #5 CLK = ~CLK;

    assign sda_bus   = sda_m & ~sda_oe;
    assign reg_rdata = rmem[reg_addr];

    i2c_target_regs #(.DEV_ADDR(DEV), .REG_AW(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .scl_in(scl_m), .sda_in(sda_bus),
        .sda_oe(sda_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .busy(busy)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          ptr_m    = 0;
    int          exp_re   = 0;
    int          we_idx   = 0;
    logic [11:0] exp_we [$];

    int          oe_high_cycles = 0;
    int          oe_changes     = 0;
    int          oe_bad_chg     = 0;
    int          re_cnt         = 0;
    int          we_re_both     = 0;
    logic        oe_prev        = 1'b0;
    logic [11:0] obs_we [$];

    // Bus/strobe monitor, sampled just after each active edge.
    always begin
        @(posedge CLK);
        #1;
        if (RST_N === 1'b1) begin
            if (sda_oe !== oe_prev) begin
                oe_changes++;
                if (scl_m !== 1'b0) oe_bad_chg++;
            end
            if (sda_oe === 1'b1) oe_high_cycles++;
            if (reg_we === 1'b1) obs_we.push_back({reg_addr, reg_wdata});
            if (reg_re === 1'b1) re_cnt++;
            if ((reg_we === 1'b1) && (reg_re === 1'b1)) we_re_both++;
        end
        oe_prev = sda_oe;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_we(input string tag);
        chk({tag, "_we_count"}, obs_we.size(), exp_we.size());
        for (int i = we_idx; (i < exp_we.size()) && (i < obs_we.size()); i++)
            chk({tag, "_we_entry"}, 32'(obs_we[i]), 32'(exp_we[i]));
        we_idx = exp_we.size();
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic bit_write(input logic b);
        sda_m = b;
        hold(Q);
        scl_m = 1'b1;
        hold(2 * Q);
        scl_m = 1'b0;
        hold(Q);
    endtask

    // Returns the level late in the high phase and whether it matched the level at the rise.
    task automatic bit_read(output logic b, output logic stable);
        logic b0;
        sda_m = 1'b1;
        hold(Q);
        scl_m = 1'b1;
        hold(1);
        b0 = sda_bus;
        hold(2 * Q - 2);
        b = sda_bus;
        hold(1);
        scl_m = 1'b0;
        hold(Q);
        stable = (b0 === b);
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        hold(Q);
        scl_m = 1'b1;
        hold(Q);
        sda_m = 1'b0;
        hold(Q);
        scl_m = 1'b0;
        hold(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        hold(Q);
        scl_m = 1'b1;
        hold(Q);
        sda_m = 1'b1;
        hold(2 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack, output logic stable);
        for (int i = 7; i >= 0; i--) bit_write(b[i]);
        bit_read(ack, stable);
    endtask

    task automatic rd_byte(output logic [7:0] b, input logic mack);
        logic bit_v, s;
        for (int i = 7; i >= 0; i--) begin
            bit_read(bit_v, s);
            b[i] = bit_v;
        end
        bit_write(mack);
    endtask

    task automatic xact_write(input logic [6:0] dev, input logic [7:0] p, input int n, input string tag);
        logic a, s, match;
        int   oe_before;
        match     = (dev == DEV);
        oe_before = oe_high_cycles;
        start_cond();
        wr_byte({dev, 1'b0}, a, s);
        chk({tag, "_addr_ack"}, 32'(a), match ? 32'd0 : 32'd1);
        if (match) chk({tag, "_ack_hold"}, 32'(s), 32'd1);
        wr_byte(p, a, s);
        chk({tag, "_ptr_ack"}, 32'(a), match ? 32'd0 : 32'd1);
        for (int i = 0; i < n; i++) begin
            wr_byte(wdat[i], a, s);
            chk({tag, "_data_ack"}, 32'(a), match ? 32'd0 : 32'd1);
            if (match) exp_we.push_back({4'((int'(p) + i) % 16), wdat[i]});
        end
        chk({tag, "_busy_in"}, 32'(busy), 32'd1);
        stop_cond();
        chk({tag, "_busy_out"}, 32'(busy), 32'd0);
        if (match) ptr_m = (int'(p) + n) % 16;
        else chk({tag, "_oe_quiet"}, oe_high_cycles - oe_before, 32'd0);
        chk({tag, "_reg_addr"}, 32'(reg_addr), ptr_m);
        check_we(tag);
    endtask

    task automatic xact_read(input logic [7:0] p, input int n, input string tag);
        logic       a, s;
        logic [7:0] b;
        start_cond();
        wr_byte({DEV, 1'b0}, a, s);
        chk({tag, "_waddr_ack"}, 32'(a), 32'd0);
        wr_byte(p, a, s);
        chk({tag, "_ptr_ack"}, 32'(a), 32'd0);
        ptr_m = int'(p) % 16;
        start_cond();
        wr_byte({DEV, 1'b1}, a, s);
        chk({tag, "_raddr_ack"}, 32'(a), 32'd0);
        chk({tag, "_ack_hold"}, 32'(s), 32'd1);
        for (int i = 0; i < n; i++) begin
            rd_byte(b, (i == n - 1));
            chk({tag, "_rdata"}, 32'(b), 32'(rmem[(ptr_m + i) % 16]));
        end
        exp_re += n;
        chk({tag, "_oe_released"}, 32'(sda_oe), 32'd0);
        stop_cond();
        ptr_m = (ptr_m + n - 1) % 16;
        chk({tag, "_reg_addr"}, 32'(reg_addr), ptr_m);
        chk({tag, "_re_count"}, re_cnt, exp_re);
        chk({tag, "_busy_out"}, 32'(busy), 32'd0);
        check_we(tag);
    endtask

    initial begin
        logic       a, s, match;
        logic [6:0] dev;
        logic [7:0] p;
        int         n, kind;

        RST_N = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        for (int i = 0; i < 16; i++) rmem[i] = 8'(8'h10 + i);
        hold(3);
        RST_N = 1'b1;
        hold(2);
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_reg_re", 32'(reg_re), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        wdat[0] = 8'h5A;
        wdat[1] = 8'hC3;
        xact_write(DEV, 8'h03, 2, "wr_dir");
        xact_read(8'h0F, 2, "rd_wrap");
        xact_write(7'h58, 8'hFF, 0, "nomatch");

        // STOP after four pointer bits
        start_cond();
        wr_byte({DEV, 1'b0}, a, s);
        chk("midstop_addr_ack", 32'(a), 32'd0);
        bit_write(1'b1);
        bit_write(1'b0);
        bit_write(1'b1);
        bit_write(1'b1);
        stop_cond();
        chk("midstop_reg_addr", 32'(reg_addr), ptr_m);
        chk("midstop_busy", 32'(busy), 32'd0);
        chk("midstop_re_count", re_cnt, exp_re);
        check_we("midstop");

        // Reset while the target drives a zero data bit
        start_cond();
        wr_byte({DEV, 1'b1}, a, s);
        chk("rstrd_addr_ack", 32'(a), 32'd0);
        exp_re++;
        chk("rstrd_oe_driving", 32'(sda_oe), 32'd1);
        RST_N = 1'b0;
        #1;
        chk("rstrd_sda_oe", 32'(sda_oe), 32'd0);
        chk("rstrd_busy", 32'(busy), 32'd0);
        chk("rstrd_reg_addr", 32'(reg_addr), 32'd0);
        hold(2);
        RST_N = 1'b1;
        ptr_m = 0;
        sda_m = 1'b1;
        hold(Q);
        scl_m = 1'b1;
        hold(2 * Q);
        chk("rstrd_re_count", re_cnt, exp_re);
        wdat[0] = 8'h3C;
        xact_write(DEV, 8'h07, 1, "wr_after_rst");

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) rmem[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 8; i++) wdat[i] = 8'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 2));
            p    = 8'($urandom_range(0, 255));
            n    = int'($urandom_range(1, 4));
            if (kind == 0) begin
                xact_write(DEV, p, n, "rnd_wr");
            end else if (kind == 1) begin
                xact_read(p, n, "rnd_rd");
            end else begin
                dev   = 7'($urandom_range(0, 127));
                match = (dev == DEV);
                if (match) dev = 7'h51;
                xact_write(dev, p, n, "rnd_nomatch");
            end
        end

        chk("oe_change_scl_high", oe_bad_chg, 32'd0);
        chk("oe_activity", 32'(oe_changes > 0), 32'd1);
        chk("we_re_overlap", we_re_both, 32'd0);
        chk("final_re_count", re_cnt, exp_re);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
